// File: rtl/hs_pkg.sv
// Shared constants and helpers for the valid/busy requester family.
package hs_pkg;

  localparam int unsigned DSIZE_DEF = 4;
  localparam int unsigned DEPTH_DEF = 4;

  // Bit width needed to index v entries, never below 1.
  function automatic int unsigned clog2_safe(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage and pointer logic only.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW   = clog2_safe(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DSIZE-1:0] i_wdata,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;

  // Extra MSB distinguishes full from empty when the index bits match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + CW'(1);
      if (i_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[PW-1:0]];
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_count == CW'(DEPTH));

endmodule

// File: rtl/hs_requester_buf.sv
// Valid/busy requester: output register fed by an elastic FIFO with empty-bypass.
module hs_requester_buf
  import hs_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned LVL_W = $clog2(DEPTH + 2),
  localparam int unsigned CW    = clog2_safe(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] data_in,
  output logic             ready_in,
  input  logic             busy,
  output logic             valid_out,
  output logic [DSIZE-1:0] data_sent,
  output logic [LVL_W-1:0] level,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic             w_acc;
  logic             w_load;
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_bypass;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [DSIZE-1:0] w_head;

  hs_sync_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (data_in),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Readiness depends only on registered pointers, never on busy.
  assign ready_in = (w_count != CW'(DEPTH));
  assign w_acc    = valid_in && ready_in;
  assign w_load   = !valid_out || !busy;
  assign w_xfer   = valid_out && !busy;
  assign w_pop    = w_load && !w_empty;
  assign w_bypass = w_load && w_empty && w_acc;
  assign w_push   = w_acc && !w_bypass && !w_full;

  // Output register; data_sent holds its last value when going idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      data_sent <= '0;
    end else if (w_load) begin
      if (!w_empty) begin
        valid_out <= 1'b1;
        data_sent <= w_head;
      end else if (w_acc) begin
        valid_out <= 1'b1;
        data_sent <= data_in;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= '0;
    end else begin
      level <= level + LVL_W'(w_acc) - LVL_W'(w_xfer);
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (valid_in && !ready_in) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_requester_buf.sv
// Directed and randomized checks for hs_requester_buf (DSIZE=4, DEPTH=4).
module tb_hs_requester_buf;

  localparam int unsigned DSIZE = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             valid_in;
  logic [DSIZE-1:0] data_in;
  logic             ready_in;
  logic             busy;
  logic             valid_out;
  logic [DSIZE-1:0] data_sent;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic             ovf_clr;

  int n_chk  = 0;
  int n_pass = 0;

  hs_requester_buf #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .busy      (busy),
    .valid_out (valid_out),
    .data_sent (data_sent),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input int d, input int l);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    if (v) chk({tag, ".data"}, 32'(data_sent), 32'(d));
    chk({tag, ".level"}, 32'(level), 32'(l));
  endtask

  task automatic drive(input logic v, input int d, input logic b);
    valid_in = v;
    data_in  = DSIZE'(d);
    busy     = b;
  endtask

  initial begin
    int q[$];
    logic held;
    logic [DSIZE-1:0] held_data;
    logic exp_rdy;
    logic acc;

    rstn = 1'b0; valid_in = 1'b0; data_in = '0; busy = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst.valid", 32'(valid_out), 0);
    chk("rst.data", 32'(data_sent), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.ready", 32'(ready_in), 1);
    rstn = 1'b1;
    step();

    // Back-to-back stream, busy low: one-cycle latency, level stays 1.
    for (int v = 1; v <= 15; v++) begin
      drive(1'b1, v, 1'b0);
      step();
      chk_out($sformatf("stream%0d", v), 1'b1, v, 1);
    end
    drive(1'b0, 0, 1'b0);
    step();
    chk_out("stream.idle", 1'b0, 0, 0);

    // Fill under busy: A goes to output, B..E buffered.
    for (int v = 10; v <= 14; v++) begin
      drive(1'b1, v, 1'b1);
      step();
    end
    drive(1'b0, 0, 1'b1);
    chk_out("full", 1'b1, 10, 5);
    chk("full.ready", 32'(ready_in), 0);

    // Overflow while full, then clear, then clear racing a new overflow.
    drive(1'b1, 7, 1'b1);
    step();
    chk("ovf.set", 32'(ovf), 1);
    chk_out("ovf.hold", 1'b1, 10, 5);
    drive(1'b0, 0, 1'b1);
    ovf_clr = 1'b1;
    step();
    chk("ovf.clr", 32'(ovf), 0);
    drive(1'b1, 7, 1'b1);
    step();
    chk("ovf.clr_vs_set", 32'(ovf), 1);
    ovf_clr = 1'b0;

    // Drain: B..E in order, 7 never appears, ready returns after first pop.
    drive(1'b0, 0, 1'b0);
    step();
    chk_out("drain.B", 1'b1, 11, 4);
    chk("drain.ready", 32'(ready_in), 1);
    step(); chk_out("drain.C", 1'b1, 12, 3);
    step(); chk_out("drain.D", 1'b1, 13, 2);
    step(); chk_out("drain.E", 1'b1, 14, 1);
    step(); chk_out("drain.empty", 1'b0, 0, 0);

    // Two buffered + one on output, then simultaneous push/pop.
    for (int v = 1; v <= 3; v++) begin
      drive(1'b1, v, 1'b1);
      step();
    end
    chk_out("pp.pre", 1'b1, 1, 3);
    for (int v = 4; v <= 7; v++) begin
      drive(1'b1, v, 1'b0);
      step();
      chk_out($sformatf("pp%0d", v), 1'b1, v - 2, 3);
    end
    drive(1'b0, 0, 1'b0);
    step(); chk_out("pp.tail6", 1'b1, 6, 2);
    step(); chk_out("pp.tail7", 1'b1, 7, 1);
    step(); chk_out("pp.empty", 1'b0, 0, 0);

    // Async reset with three words buffered and busy high.
    for (int v = 9; v <= 12; v++) begin
      drive(1'b1, v, 1'b1);
      step();
    end
    drive(1'b0, 0, 1'b1);
    chk("mrst.pre_level", 32'(level), 4);
    #2 rstn = 1'b0;
    #1;
    chk("mrst.valid", 32'(valid_out), 0);
    chk("mrst.data", 32'(data_sent), 0);
    chk("mrst.level", 32'(level), 0);
    chk("mrst.ready", 32'(ready_in), 1);
    step();
    rstn = 1'b1;
    drive(1'b0, 0, 1'b0);
    step();
    chk_out("mrst.after", 1'b0, 0, 0);
    chk("mrst.after_ready", 32'(ready_in), 1);
    chk("mrst.after_ovf", 32'(ovf), 0);

    // Random traffic against a queue model; q[0] is the word on the output.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      exp_rdy = (q.size() <= DEPTH);
      chk("rnd.ready", 32'(ready_in), 32'(exp_rdy));
      held = valid_out && busy;
      held_data = data_sent;
      acc = valid_in && exp_rdy;
      if (q.size() > 0 && !busy) void'(q.pop_front());
      if (acc) q.push_back(int'(data_in));
      step();
      chk("rnd.valid", 32'(valid_out), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd.data", 32'(data_sent), 32'(q[0]));
      chk("rnd.level", 32'(level), 32'(q.size()));
      if (held) chk("rnd.stable", 32'(data_sent), 32'(held_data));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
